// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN elevator controller with car/hall call latching, travel and door timing
module elevator_scheduler #(
    parameter int  FLOORS        = 8,
    parameter int  TRAVEL_CYCLES = 4,
    parameter int  DOOR_CYCLES   = 3,
    localparam int FLOOR_W       = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  car_req,
    input  logic [FLOORS-1:0]  hall_up,
    input  logic [FLOORS-1:0]  hall_dn,
    output logic [FLOORS-1:0]  pending_car,
    output logic [FLOORS-1:0]  pending_up,
    output logic [FLOORS-1:0]  pending_dn,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  floor_onehot,
    output logic               moving,
    output logic               dir,
    output logic               door_open,
    output logic               arrive
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOORS-1:0]   BIT0        = FLOORS'(1);
    // No up call above the top floor, no down call below the bottom one
    localparam logic [FLOORS-1:0]   UP_MASK     = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]   DN_MASK     = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [1:0]          state, stateNext;
    logic [TRAVEL_W-1:0] travelCnt, travelNext;
    logic [DOOR_W-1:0]   doorCnt, doorNext;
    logic [FLOOR_W-1:0]  floorNext, nextFloor;
    logic                dirNext, arriveNext;
    logic [FLOORS-1:0]   clrCar, clrUp, clrDn;
    logic [FLOORS-1:0]   allPend, curOnehot, nextOnehot, absorb;
    logic                callHere, aheadNow, behindNow, aheadNext;
    logic                sameHall, oppHall, stopHere, reversal, reqHere;

    // True if any call lies strictly above (up=1) or strictly below (up=0) floor f
    function automatic logic callsBeyond(input logic [FLOORS-1:0] calls,
                                         input logic [FLOOR_W-1:0] f,
                                         input logic up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (up && (FLOOR_W'(i) > f)) hit = hit | calls[i];
            if (!up && (FLOOR_W'(i) < f)) hit = hit | calls[i];
        end
        return hit;
    endfunction

    assign allPend      = pending_car | pending_up | pending_dn;
    assign curOnehot    = BIT0 << cur_floor;
    assign floor_onehot = curOnehot;
    assign callHere     = |(allPend & curOnehot);
    assign aheadNow     = callsBeyond(allPend, cur_floor, dir);
    assign behindNow    = callsBeyond(allPend, cur_floor, ~dir);

    // The floor reached at the end of the current travel step, clamped at both ends
    assign nextFloor  = dir ? ((cur_floor == TOP_FLOOR) ? cur_floor : cur_floor + 1'b1)
                            : ((cur_floor == '0) ? cur_floor : cur_floor - 1'b1);
    assign nextOnehot = BIT0 << nextFloor;
    assign aheadNext  = callsBeyond(allPend, nextFloor, dir);
    assign sameHall   = dir ? pending_up[nextFloor] : pending_dn[nextFloor];
    assign oppHall    = dir ? pending_dn[nextFloor] : pending_up[nextFloor];
    assign stopHere   = pending_car[nextFloor] | sameHall | (~aheadNext & oppHall);
    assign reversal   = ~aheadNext & oppHall & ~sameHall;

    // With the door open, a press at this floor just holds the door instead of latching
    assign absorb  = (state == ST_DOOR) ? curOnehot : '0;
    assign reqHere = |((car_req | (hall_up & UP_MASK) | (hall_dn & DN_MASK)) & curOnehot);

    // SCAN dispatch: next state, direction, counters and the call bits served this edge
    always_comb begin
        stateNext  = state;
        dirNext    = dir;
        floorNext  = cur_floor;
        travelNext = travelCnt;
        doorNext   = doorCnt;
        arriveNext = 1'b0;
        clrCar     = '0;
        clrUp      = '0;
        clrDn      = '0;
        case (state)
            ST_IDLE: begin
                if (callHere) begin
                    stateNext = ST_DOOR;
                    doorNext  = '0;
                    clrCar    = curOnehot;
                    clrUp     = curOnehot;
                    clrDn     = curOnehot;
                end else if (aheadNow) begin
                    stateNext  = ST_MOVE;
                    travelNext = '0;
                end else if (behindNow) begin
                    stateNext  = ST_MOVE;
                    dirNext    = ~dir;
                    travelNext = '0;
                end
            end
            ST_MOVE: begin
                if (travelCnt == TRAVEL_LAST) begin
                    travelNext = '0;
                    floorNext  = nextFloor;
                    arriveNext = (nextFloor != cur_floor);
                    if (stopHere) begin
                        stateNext = ST_DOOR;
                        doorNext  = '0;
                        clrCar    = nextOnehot;
                        if (dir) clrUp = nextOnehot;
                        else     clrDn = nextOnehot;
                        if (reversal) begin
                            dirNext = ~dir;
                            if (dir) clrDn = nextOnehot;
                            else     clrUp = nextOnehot;
                        end
                    end else if (!aheadNext) begin
                        stateNext = ST_IDLE;
                    end
                end else begin
                    travelNext = travelCnt + 1'b1;
                end
            end
            ST_DOOR: begin
                if (reqHere) begin
                    doorNext = '0;
                end else if (doorCnt == DOOR_LAST) begin
                    if (aheadNow) begin
                        stateNext  = ST_MOVE;
                        travelNext = '0;
                    end else if (behindNow) begin
                        stateNext  = ST_MOVE;
                        dirNext    = ~dir;
                        travelNext = '0;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end else begin
                    doorNext = doorCnt + 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, position, call latches and registered status outputs; clears beat same-edge sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_floor   <= '0;
            dir         <= 1'b1;
            travelCnt   <= '0;
            doorCnt     <= '0;
            pending_car <= '0;
            pending_up  <= '0;
            pending_dn  <= '0;
            moving      <= 1'b0;
            door_open   <= 1'b0;
            arrive      <= 1'b0;
        end else begin
            state       <= stateNext;
            cur_floor   <= floorNext;
            dir         <= dirNext;
            travelCnt   <= travelNext;
            doorCnt     <= doorNext;
            pending_car <= (pending_car | (car_req & ~absorb)) & ~clrCar;
            pending_up  <= (pending_up | (hall_up & UP_MASK & ~absorb)) & ~clrUp;
            pending_dn  <= (pending_dn | (hall_dn & DN_MASK & ~absorb)) & ~clrDn;
            moving      <= (stateNext == ST_MOVE);
            door_open   <= (stateNext == ST_DOOR);
            arrive      <= arriveNext;
        end
    end

endmodule
